// File: rtl/conv3x3_stream_engine.sv
// conv3x3_stream_engine: streaming 3x3 convolution for one pixel channel.
// AXI-Stream in/out with full backpressure, runtime weights/bias, and frame tracking
// that emits only interior windows. The output pipeline has three stages: products,
// adder tree with bias, then shift and saturate.
// Build option: define CONV_RELU_EN to clamp negative results to 0 after saturation.
module conv3x3_stream_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int W_WIDTH    = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  cfg_we,
  input  logic [3:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int PROD_W = DATA_WIDTH + W_WIDTH + 1;
  localparam int ACC_W  = DATA_WIDTH + W_WIDTH + 5;
  // Leave room for the full 32-bit bias on top of the product sum.
  localparam int SUM_W  = ((ACC_W > 32) ? ACC_W : 32) + 1;
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);

  logic                        pipe_en, accept;
  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic                        at_end, in_win, s1_vld, s1_last, drain_done, end_pend;
  logic [3:1]                  vld_pipe, last_pipe;
  logic [DATA_WIDTH-1:0]       lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]       lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]       win     [3][3];
  logic [DATA_WIDTH-1:0]       win_nxt [3][3];
  logic signed [W_WIDTH-1:0]   wgt [9];
  logic signed [31:0]          bias;
  logic signed [PROD_W-1:0]    prod [9];
  logic signed [SUM_W-1:0]     sum_c, acc2, shifted;
  logic signed [OUT_WIDTH-1:0] sat_v, res_v, out_q;

  // A stalled output freezes the whole pipeline, input included.
  assign pipe_en       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = pipe_en && !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign at_end  = (row == ROW_W'(IMG_HEIGHT-1)) && (col == COL_W'(IMG_WIDTH-1));
  assign in_win  = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign s1_vld  = accept && in_win;
  assign s1_last = s1_vld && at_end;

  // Pipeline drains empty on this edge: nothing left behind the output register.
  assign drain_done = pipe_en && !vld_pipe[1] && !vld_pipe[2];

  assign m_axis_tvalid = vld_pipe[3];
  assign m_axis_tlast  = last_pipe[3];
  assign m_axis_tdata  = out_q;

  // Raster position, frame-error flag and busy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      end_pend  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        if (s_axis_tlast != at_end) frame_err <= 1'b1;
        if (s_axis_tlast && !at_end) begin
          col <= '0;
          row <= '0;
        end else if (col == COL_W'(IMG_WIDTH-1)) begin
          col <= '0;
          row <= (row == ROW_W'(IMG_HEIGHT-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        busy     <= 1'b1;
        end_pend <= s_axis_tlast || at_end;
      end else if (end_pend && drain_done) begin
        busy     <= 1'b0;
        end_pend <= 1'b0;
      end
    end
  end

  // Line buffers: lb0 holds the previous line, lb1 the one before it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= lb0[col];
      lb0[col] <= s_axis_tdata;
    end
  end

  // Window as it will be after this beat; products are taken from it directly.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 2; c++)
        win_nxt[r][c] = win[r][c+1];
    win_nxt[0][2] = lb1[col];
    win_nxt[1][2] = lb0[col];
    win_nxt[2][2] = s_axis_tdata;
  end

  // 3x3 window shift register, advanced once per accepted beat.
  always_ff @(posedge clk) begin
    if (accept) win <= win_nxt;
  end

  // Weight/bias registers; writes are ignored while a frame is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++)
        wgt[k] <= (k == 4) ? W_WIDTH'(8) : {W_WIDTH{1'b1}};
      bias <= '0;
    end else if (cfg_we && !busy) begin
      for (int k = 0; k < 9; k++)
        if (cfg_addr == 4'(k)) wgt[k] <= cfg_wdata[W_WIDTH-1:0];
      if (cfg_addr == 4'd9) bias <= cfg_wdata;
    end
  end

  // Valid/last shift register across the three stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else if (pipe_en) begin
      vld_pipe  <= {vld_pipe[2:1], s1_vld};
      last_pipe <= {last_pipe[2:1], s1_last};
    end
  end

  // Adder tree plus sign-extended bias.
  always_comb begin
    sum_c = SUM_W'(bias);
    for (int k = 0; k < 9; k++) sum_c = sum_c + SUM_W'(prod[k]);
  end

  // S1 products (pixel zero-extended) and S2 accumulator.
  always_ff @(posedge clk) begin
    if (pipe_en) begin
      for (int k = 0; k < 9; k++)
        prod[k] <= $signed({1'b0, win_nxt[k/3][k%3]}) * wgt[k];
      acc2 <= sum_c;
    end
  end

  assign shifted = acc2 >>> OUT_SHIFT;

  generate
    if (OUT_WIDTH >= SUM_W) begin : g_nosat
      assign sat_v = OUT_WIDTH'(shifted);
    end else begin : g_sat
      localparam logic signed [SUM_W-1:0] MAXV =
        {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
      localparam logic signed [SUM_W-1:0] MINV = ~MAXV;
      assign sat_v = (shifted > MAXV) ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                     (shifted < MINV) ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                     shifted[OUT_WIDTH-1:0];
    end
  endgenerate

`ifdef CONV_RELU_EN
  assign res_v = sat_v[OUT_WIDTH-1] ? '0 : sat_v;
`else
  assign res_v = sat_v;
`endif

  // S3 output data register; held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else if (pipe_en) out_q <= res_v;
  end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Bench for conv3x3_stream_engine on a 5x5 image: a 32-bit and an 8-bit output
// instance share stimulus and are checked against a frame-level reference model.
module tb_conv3x3_stream_engine;

  localparam int IW = 5, IH = 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic        s_tready, m_tvalid, m_tlast, busy, frame_err;
  logic [31:0] m_tdata;
  logic        s_tready8, m_tvalid8, m_tlast8, busy8, ferr8;
  logic [7:0]  m_tdata8;

  always #5 clk = ~clk;

  conv3x3_stream_engine #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH)) u_dut (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy),
    .frame_err(frame_err));

  conv3x3_stream_engine #(.OUT_WIDTH(8), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) u_dut8 (
    .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready8), .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata8),
    .m_axis_tvalid(m_tvalid8), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast8),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy8),
    .frame_err(ferr8));

  typedef struct { longint d32; longint d8; bit last; } exp_t;
  typedef struct {
    bit do_rst; bit set_w; int w_all; int bias; int fill; int imp; bit busy_wr;
    int e_ctr; int e_oth; int e8_ctr; int e8_oth;
  } vec_t;

  int     checks = 0, errors = 0;
  int     mw [9];
  longint mbias;
  int     img [IH][IW];
  int     mrow, mcol;
  bit     exp_err;
  exp_t   exp_q [$];
  exp_t   e;
  longint got_q [$], got8_q [$];
  bit     rnd_ready = 1'b0;
  bit     hold_pend = 1'b0;
  logic [31:0] hold_d;
  logic   hold_l;
  logic   busy_mid;
  vec_t   vt [3];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint rl(input longint v);
`ifdef CONV_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic longint sat(input longint v, input int ow);
    longint mx, mn;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) v = mx;
    else if (v < mn) v = mn;
    return rl(v);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 9; k++) mw[k] = (k == 4) ? 8 : -1;
    mbias = 0; mrow = 0; mcol = 0; exp_err = 1'b0;
    exp_q.delete();
  endfunction

  // Reference: store the frame as an image, convolve each full 3x3 neighbourhood.
  function automatic void model_accept(input int pix, input bit last);
    bit     at_end;
    longint acc;
    exp_t   x;
    img[mrow][mcol] = pix;
    at_end = (mrow == IH-1) && (mcol == IW-1);
    if (last != at_end) exp_err = 1'b1;
    if (mrow >= 2 && mcol >= 2) begin
      acc = mbias;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          acc += longint'(mw[i*3+j]) * img[mrow-2+i][mcol-2+j];
      x.d32 = sat(acc, 32); x.d8 = sat(acc, 8); x.last = at_end;
      exp_q.push_back(x);
    end
    if (last && !at_end) begin
      mrow = 0; mcol = 0;
    end else begin
      mcol++;
      if (mcol == IW) begin
        mcol = 0; mrow++;
        if (mrow == IH) mrow = 0;
      end
    end
  endfunction

  // Monitor: model input beats, check output beats and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (s_tvalid && s_tready) model_accept(int'(s_tdata), s_tlast);
      if (hold_pend) begin
        chk("hold_valid", longint'(m_tvalid), 1);
        chk("hold_data", longint'(m_tdata), longint'(hold_d));
        chk("hold_last", longint'(m_tlast), longint'(hold_l));
      end
      hold_pend = m_tvalid && !m_tready;
      hold_d = m_tdata; hold_l = m_tlast;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", longint'(m_tdata), -999999);
        end else begin
          e = exp_q.pop_front();
          chk("data32", longint'($signed(m_tdata)), e.d32);
          chk("valid8", longint'(m_tvalid8), 1);
          chk("data8", longint'($signed(m_tdata8)), e.d8);
          chk("tlast", longint'(m_tlast), longint'(e.last));
          chk("tlast8", longint'(m_tlast8), longint'(e.last));
          got_q.push_back(longint'($signed(m_tdata)));
          got8_q.push_back(longint'($signed(m_tdata8)));
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_tready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input int data, input bit applied);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = 32'(data);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (applied) begin
      if (addr <= 8) mw[addr] = int'($signed(8'(data)));
      else if (addr == 9) mbias = longint'(data);
    end
  endtask

  task automatic send_pix(input int pix, input bit last, input int gap_pct);
    bit acc;
    int n;
    if (int'($urandom_range(99)) < gap_pct) begin
      s_tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1; s_tdata = 8'(pix); s_tlast = last;
    n = 0;
    do begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("accept_timeout", 0, 1);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // fill<0 means random pixels; imp>=0 places an impulse at (2,2).
  task automatic send_frame(input int fill, input int imp, input int gap,
                            input int early, input bit busy_wr);
    int pix;
    bit last;
    for (int idx = 0; idx < IW*IH; idx++) begin
      if (early >= 0 && idx > early) break;
      pix  = (fill < 0) ? int'($urandom_range(255)) : fill;
      if (imp >= 0 && idx == 2*IW + 2) pix = imp;
      last = (early >= 0) ? (idx == early) : (idx == IW*IH - 1);
      if (busy_wr && idx == 10) begin
        cfg_we = 1'b1; cfg_addr = 4'd4; cfg_wdata = 32'd50;
      end
      send_pix(pix, last, gap);
      cfg_we = 1'b0;
      if (idx == 5) busy_mid = busy;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1);
  end

  initial begin
    vt[0] = '{do_rst:1, set_w:0, w_all:0, bias:0, fill:10, imp:-1, busy_wr:0,
              e_ctr:0, e_oth:0, e8_ctr:0, e8_oth:0};
    vt[1] = '{do_rst:1, set_w:0, w_all:0, bias:0, fill:0, imp:100, busy_wr:0,
              e_ctr:800, e_oth:int'(rl(-100)), e8_ctr:127, e8_oth:int'(rl(-100))};
    vt[2] = '{do_rst:0, set_w:1, w_all:1, bias:-5, fill:255, imp:-1, busy_wr:1,
              e_ctr:2290, e_oth:2290, e8_ctr:127, e8_oth:127};

    model_reset();
    @(posedge clk); #1;
    chk("rst_tready", longint'(s_tready), 0);
    chk("rst_tvalid", longint'(m_tvalid), 0);
    chk("rst_tlast", longint'(m_tlast), 0);
    chk("rst_tdata", longint'(m_tdata), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ferr", longint'(frame_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("post_rst_tready", longint'(s_tready), 1);

    // Directed frames from the vector table.
    foreach (vt[v]) begin
      if (vt[v].do_rst) do_reset(2);
      if (vt[v].set_w) begin
        for (int k = 0; k < 9; k++) cfg_write(k, vt[v].w_all, 1'b1);
        cfg_write(9, vt[v].bias, 1'b1);
      end
      got_q.delete(); got8_q.delete();
      send_frame(vt[v].fill, vt[v].imp, 0, -1, vt[v].busy_wr);
      wait_drain();
      chk("vec_count", got_q.size(), 9);
      for (int i = 0; i < 9 && i < got_q.size(); i++) begin
        chk("vec_data32", got_q[i], (i == 4) ? vt[v].e_ctr : vt[v].e_oth);
        chk("vec_data8", got8_q[i], (i == 4) ? vt[v].e8_ctr : vt[v].e8_oth);
      end
      chk("vec_busy_mid", longint'(busy_mid), 1);
      chk("vec_busy_end", longint'(busy), 0);
      chk("vec_busy8_end", longint'(busy8), 0);
      chk("vec_ferr", longint'(frame_err), 0);
      chk("vec_ferr8", longint'(ferr8), 0);
    end

    // Random weights, pixels, backpressure and input gaps.
    rnd_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 9; k++) cfg_write(k, int'($urandom_range(255)), 1'b1);
      cfg_write(9, int'($urandom_range(200000)) - 100000, 1'b1);
      got_q.delete();
      send_frame(-1, -1, 30, -1, 1'b0);
      wait_drain();
      chk("rnd_count", got_q.size(), 9);
      chk("rnd_ferr", longint'(frame_err), longint'(exp_err));
    end
    rnd_ready = 1'b0;

    // Early tlast on the 12th pixel: no output, sticky error, then a clean frame.
    got_q.delete();
    send_frame(7, -1, 0, 11, 1'b0);
    wait_drain();
    chk("early_count", got_q.size(), 0);
    chk("early_ferr", longint'(frame_err), 1);
    chk("early_ferr_model", longint'(exp_err), 1);
    chk("early_busy", longint'(busy), 0);
    got_q.delete();
    send_frame(-1, -1, 10, -1, 1'b0);
    wait_drain();
    chk("resync_count", got_q.size(), 9);
    chk("resync_ferr_sticky", longint'(frame_err), 1);

    // Reset mid-frame: in-flight results vanish, weights return to defaults.
    got_q.delete();
    for (int idx = 0; idx < 15; idx++) send_pix(3 + idx, 1'b0, 0);
    do_reset(1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_count", got_q.size(), 0);
    chk("midrst_tvalid", longint'(m_tvalid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_ferr", longint'(frame_err), 0);
    got_q.delete();
    send_frame(0, 100, 0, -1, 1'b0);
    wait_drain();
    chk("midrst_after_count", got_q.size(), 9);
    if (got_q.size() == 9) chk("midrst_default_w", got_q[4], 800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
